mag_to_bcd: RTL

MAG_TO_BCD -- requirements
Module: mag_to_bcd

---
 rtl/mag_to_bcd_pkg.sv | 21 ++
 rtl/mag_to_bcd_add3.sv | 15 +
 rtl/mag_to_bcd.sv | 97 +++++++++
 3 files changed

// File: rtl/mag_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mag_to_bcd_pkg
// Purpose  : Shared FSM state type and BCD digit-count helper for mag_to_bcd.
// Revision : 1.0 - initial release
// ============================================================================
package mag_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Three binary bits per decimal digit, rounded up.
    function automatic int calc_digits(input int n);
        return (n + 2) / 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mag_to_bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Purpose  : Double-dabble digit correction: add 3 to a BCD digit >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule
`default_nettype wire

// File: rtl/mag_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : mag_to_bcd
// Purpose  : Sequential shift-add-3 converter from unsigned magnitude plus
//            sign to packed BCD, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mag_to_bcd
    import mag_to_bcd_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [N-1:0]                    mag,
    input  logic                            neg,
    output logic                            busy,
    output logic                            done,
    output logic [4*calc_digits(N)-1:0]     bcd,
    output logic                            sign_out
);

    localparam int c_digits = calc_digits(N);
    localparam int c_bcd_w  = 4 * c_digits;
    localparam int c_cnt_w  = $clog2(N + 1);

    state_e               r_state;
    logic [N-1:0]         r_shreg;
    logic [c_bcd_w-1:0]   r_scratch;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;

    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w+N-1:0] w_next;

    generate
        for (genvar g = 0; g < c_digits; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_scratch[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // Corrected digits and remaining magnitude bits move left as one word.
    assign w_next = {w_adj, r_shreg} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            sign_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shreg   <= mag;
                        r_scratch <= '0;
                        r_cnt     <= c_cnt_w'(N);
                        r_neg     <= neg;
                        busy      <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_next[c_bcd_w+N-1:N];
                    r_shreg   <= w_next[N-1:0];
                    r_cnt     <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd      <= r_scratch;
                    sign_out <= r_neg & (|r_scratch);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
